// File: rtl/fifo_wr_serializer.sv
// Write-side producer for async_fifo: accepts wide words over valid/ready and
// emits them as RATIO narrow beats on the FIFO write port, stalling on full.
module fifo_wr_serializer #(
  parameter int DATA_WIDTH = 4,
  parameter int RATIO      = 4,
  parameter int CNT_WIDTH  = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH*RATIO-1:0]   s_data,
  input  logic                          s_last,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          busy,
  output logic                          frame_done,
  output logic [CNT_WIDTH-1:0]          word_cnt
);

  localparam int WORD_W = DATA_WIDTH * RATIO;
  localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WORD_W-1:0]   shreg;
  logic [BEAT_W-1:0]   beat;
  logic                last_flag;
  logic                accept;
  logic                beat_wr;
  logic                word_done;

  // Beat 0 always sits in the low slice so the shifter only ever shifts right.
  function automatic logic [WORD_W-1:0] order_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    if (MSB_FIRST) begin
      for (int i = 0; i < RATIO; i++) begin
        r[i*DATA_WIDTH +: DATA_WIDTH] = w[(RATIO-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return r;
  endfunction

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    fifo_wr_en = 1'b0;
    beat_wr    = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        fifo_wr_en = ~fifo_full;
        beat_wr    = ~fifo_full;
        word_done  = beat_wr && (beat == LAST_BEAT);
        // Ready only on the final write so the next word follows with no bubble.
        s_ready    = word_done;
        if (word_done && !s_valid) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  assign accept       = s_valid && s_ready;
  assign busy         = (state == SEND);
  assign fifo_wr_data = shreg[DATA_WIDTH-1:0];

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      shreg      <= '0;
      beat       <= '0;
      last_flag  <= 1'b0;
      word_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= word_done && last_flag;
      if (word_done) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (accept) begin
        shreg     <= order_word(s_data);
        last_flag <= s_last;
        beat      <= '0;
      end else if (beat_wr && !word_done) begin
        shreg <= shreg >> DATA_WIDTH;
        beat  <= beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_serializer.sv
// Scoreboard bench for fifo_wr_serializer: LSB-first/16-bit-count and
// MSB-first/2-bit-count instances share one stimulus stream.
module tb_fifo_wr_serializer;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_last = 1'b0;
  logic        fifo_full = 1'b0;

  logic        s_ready_a, fifo_wr_en_a, busy_a, frame_done_a;
  logic [3:0]  fifo_wr_data_a;
  logic [15:0] word_cnt_a;
  logic        s_ready_b, fifo_wr_en_b, busy_b, frame_done_b;
  logic [3:0]  fifo_wr_data_b;
  logic [1:0]  word_cnt_b;

  fifo_wr_serializer #(.DATA_WIDTH(4), .RATIO(4), .CNT_WIDTH(16), .MSB_FIRST(1'b0)) dut_a (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_data(s_data), .s_last(s_last), .fifo_wr_en(fifo_wr_en_a),
    .fifo_wr_data(fifo_wr_data_a), .fifo_full(fifo_full), .busy(busy_a),
    .frame_done(frame_done_a), .word_cnt(word_cnt_a)
  );

  fifo_wr_serializer #(.DATA_WIDTH(4), .RATIO(4), .CNT_WIDTH(2), .MSB_FIRST(1'b1)) dut_b (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_data(s_data), .s_last(s_last), .fifo_wr_en(fifo_wr_en_b),
    .fifo_wr_data(fifo_wr_data_b), .fifo_full(fifo_full), .busy(busy_b),
    .frame_done(frame_done_b), .word_cnt(word_cnt_b)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic [3:0] lsb;
    logic [3:0] msb;
    bit         eow;
    bit         last;
  } beat_t;

  beat_t       q[$];
  logic [15:0] cnt_a = 16'h0;
  logic [1:0]  cnt_b = 2'h0;
  bit          exp_fd = 1'b0;
  int          checks = 0;
  int          errors = 0;
  bit          m_busy, m_wr;
  beat_t       m_e;
  bit          acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] d, input bit l);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.lsb  = d[4*i +: 4];
      b.msb  = d[4*(3-i) +: 4];
      b.eow  = (i == 3);
      b.last = l;
      q.push_back(b);
    end
  endtask

  // Monitor: the pending-beat queue is the whole reference state.
  always @(negedge wr_clk) begin
    if (!wr_rst_n) begin
      q.delete();
      cnt_a  = 16'h0;
      cnt_b  = 2'h0;
      exp_fd = 1'b0;
    end
    m_busy = (q.size() != 0);
    m_wr   = m_busy && !fifo_full;
    chk("busy_a", 32'(busy_a), 32'(m_busy));
    chk("busy_b", 32'(busy_b), 32'(m_busy));
    chk("wr_en_a", 32'(fifo_wr_en_a), 32'(m_wr));
    chk("wr_en_b", 32'(fifo_wr_en_b), 32'(m_wr));
    if (m_busy) begin
      chk("wr_data_a", 32'(fifo_wr_data_a), 32'(q[0].lsb));
      chk("wr_data_b", 32'(fifo_wr_data_b), 32'(q[0].msb));
    end
    chk("frame_done_a", 32'(frame_done_a), 32'(exp_fd));
    chk("frame_done_b", 32'(frame_done_b), 32'(exp_fd));
    chk("word_cnt_a", 32'(word_cnt_a), 32'(cnt_a));
    chk("word_cnt_b", 32'(word_cnt_b), 32'(cnt_b));
    exp_fd = 1'b0;
    if (m_wr) begin
      m_e = q.pop_front();
      if (m_e.eow) begin
        cnt_a  = cnt_a + 16'd1;
        cnt_b  = cnt_b + 2'd1;
        exp_fd = m_e.last;
      end
    end
    chk("s_ready_a", 32'(s_ready_a), 32'(q.size() == 0));
    chk("s_ready_b", 32'(s_ready_b), 32'(q.size() == 0));
  end

  // One cycle of stimulus; a word is accepted when nothing remains pending.
  task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic f,
                       output bit a);
    @(posedge wr_clk);
    #1;
    s_valid   = v;
    s_data    = d;
    s_last    = l;
    fifo_full = f;
    @(negedge wr_clk);
    #1;
    a = v && wr_rst_n && (q.size() == 0);
    if (a) push_word(d, l);
  endtask

  task automatic send_word(input logic [15:0] d, input logic l, input bit rnd_full);
    bit a;
    int n;
    n = 0;
    a = 1'b0;
    while (!a && n < 2000) begin
      drive(1'b1, d, l, rnd_full ? ($urandom_range(3) == 0) : 1'b0, a);
      n++;
    end
    chk("accept_timeout", 32'(a), 32'd1);
  endtask

  task automatic idle(input int n, input bit rnd_full);
    bit a;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 16'($urandom), 1'($urandom), rnd_full ? ($urandom_range(3) == 0) : 1'b0, a);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge wr_clk);
    #1;
    wr_rst_n  = 1'b0;
    s_valid   = 1'b0;
    fifo_full = 1'b0;
    repeat (n) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;

    // Single word with frame end.
    send_word(16'hA5C3, 1'b1, 1'b0);
    idle(6, 1'b0);

    // Back-to-back words with s_valid held.
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 1'b0);
    idle(6, 1'b0);

    // Three-cycle full stall after the first beat.
    send_word(16'hA5C3, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, acc);
    repeat (3) drive(1'b0, 16'h0, 1'b0, 1'b1, acc);
    idle(6, 1'b0);

    // Reset mid-word, then a clean word.
    send_word(16'h4321, 1'b1, 1'b0);
    idle(2, 1'b0);
    do_reset(2);
    send_word(16'hBEEF, 1'b1, 1'b0);
    idle(6, 1'b0);

    // Randomized traffic with random gaps and back-pressure.
    for (int w = 0; w < 300; w++) begin
      idle($urandom_range(2), 1'b1);
      send_word(16'($urandom), 1'($urandom), 1'b1);
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      idle(1, 1'b0);
      n++;
    end
    idle(3, 1'b0);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
